stream_mux_rr: RTL and testbench

//  Parametrised N-to-1 streaming mux; successor to the fixed 4:1 combinational data mux.

---
 rtl/stream_mux_rr.sv | 223 ++++++++++++++++++++++
 tb/tb_stream_mux_rr.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// NUM_CH-to-1 valid/ready stream mux, fixed-select or round-robin, locked per packet.
// Define STREAM_MUX_SKID_EN to add a 2-entry skid buffer that makes in_ready registered.
module stream_mux_rr #(
    parameter int WIDTH     = 64,
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_WIDTH-1:0]    sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SEL_WIDTH-1:0]    out_ch
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 mode_q, mode_d;

    logic [WIDTH-1:0]     out_data_q;
    logic                 out_valid_q, out_last_q;
    logic [SEL_WIDTH-1:0] out_ch_q;

    logic                 out_slot_free;
    logic [WIDTH-1:0]     cur_data;
    logic                 cur_valid, cur_last;
    logic                 accept;
    logic                 pick_vld;
    logic [SEL_WIDTH-1:0] pick_ch;
    logic                 hi_vld, lo_vld;
    logic [SEL_WIDTH-1:0] hi_ch, lo_ch;

    assign out_slot_free = !out_valid_q || out_ready;

    // Beat currently presented by the locked channel.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == SEL_WIDTH'(c)) begin
                cur_data  = in_data[c*WIDTH +: WIDTH];
                cur_valid = in_valid[c];
                cur_last  = in_last[c];
            end
        end
    end

    // Round-robin search order is rr_ptr+1 .. NUM_CH-1, then 0 .. rr_ptr; lowest index wins in each half.
    always_comb begin
        hi_vld   = 1'b0;
        hi_ch    = '0;
        lo_vld   = 1'b0;
        lo_ch    = '0;
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (in_valid[c]) begin
                if (c > int'(rr_ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_ch  = SEL_WIDTH'(c);
                end else begin
                    lo_vld = 1'b1;
                    lo_ch  = SEL_WIDTH'(c);
                end
            end
        end
        if (!mode) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel == SEL_WIDTH'(c) && in_valid[c]) begin
                    pick_vld = 1'b1;
                    pick_ch  = SEL_WIDTH'(c);
                end
            end
        end else if (hi_vld) begin
            pick_vld = 1'b1;
            pick_ch  = hi_ch;
        end else if (lo_vld) begin
            pick_vld = 1'b1;
            pick_ch  = lo_ch;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = LOCKED;
                    grant_d = pick_ch;
                    mode_d  = mode;
                end
            end
            LOCKED: begin
                if (accept && cur_last) begin
                    state_d = IDLE;
                    if (mode_q) rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= SEL_WIDTH'(NUM_CH - 1);
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            mode_q   <= mode_d;
        end
    end

`ifdef STREAM_MUX_SKID_EN
    localparam int EW = WIDTH + 1 + SEL_WIDTH;

    logic [NUM_CH-1:0] in_ready_q, in_ready_d;
    logic [EW-1:0]     sk_q [2];
    logic [1:0]        cnt_q, cnt_d;
    logic              pop, direct, push, wr_idx;
    logic [EW-1:0]     cur_ent;

    assign cur_ent = {cur_last, grant_q, cur_data};
    assign accept  = cur_valid && (in_ready_q != '0);
    assign pop     = (cnt_q != 2'd0) && out_slot_free;
    assign direct  = accept && (cnt_q == 2'd0) && out_slot_free;
    assign push    = accept && !direct;
    assign wr_idx  = (cnt_q == 2'd2) || (cnt_q == 2'd1 && !pop);
    assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

    // Ready for the next cycle is decided from the post-edge skid occupancy only.
    always_comb begin
        in_ready_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready_d[c] = (state_d == LOCKED) && (grant_d == SEL_WIDTH'(c)) && (cnt_d != 2'd2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= '0;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            if (pop) begin
                {out_last_q, out_ch_q, out_data_q} <= sk_q[0];
                out_valid_q <= 1'b1;
            end else if (direct) begin
                {out_last_q, out_ch_q, out_data_q} <= cur_ent;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) sk_q[0] <= sk_q[1];
        if (push) begin
            if (wr_idx) sk_q[1] <= cur_ent;
            else        sk_q[0] <= cur_ent;
        end
    end

    assign in_ready = in_ready_q;
`else
    logic lock_rdy;

    assign lock_rdy = (state_q == LOCKED) && out_slot_free;
    assign accept   = lock_rdy && cur_valid;

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c] = lock_rdy && (grant_q == SEL_WIDTH'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cur_data;
            out_last_q  <= cur_last;
            out_ch_q    <= grant_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed select, round-robin, backpressure, bad select.
module tb_stream_mux_rr;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [255:0] in_data;
    logic [3:0]   in_valid, in_last, in_ready;
    logic [63:0]  out_data;
    logic         out_valid, out_last, out_ready;
    logic [1:0]   out_ch;

    logic         mode3;
    logic [1:0]   sel3;
    logic [191:0] in_data3;
    logic [2:0]   in_valid3, in_last3, in_ready3;
    logic [63:0]  out_data3;
    logic         out_valid3, out_last3, out_ready3;
    logic [1:0]   out_ch3;

    int passed = 0;
    int total  = 0;
    int bc [4];
    int rx;
    logic [3:0] rdy;
    logic       ovt;
    logic [63:0] od;
    int order [3] = '{0, 1, 3};

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(64), .NUM_CH(4), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .out_ch(out_ch)
    );

    stream_mux_rr #(.WIDTH(64), .NUM_CH(3), .SEL_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
        .out_ready(out_ready3), .out_ch(out_ch3)
    );

    function automatic logic [63:0] dv(input int c, input int b);
        return 64'h5A00_0000_0000_0000 | (64'(c) << 8) | 64'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input logic v, input logic l, input logic [63:0] d);
        in_valid[c] = v;
        in_last[c]  = l;
        in_data[c*64 +: 64] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0;
        out_ready = 1'b1; mode = 1'b0; sel = '0;
        for (int c = 0; c < 4; c++) bc[c] = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_last",  64'(out_last), 64'd0);
        chk("rst_out_ch",    64'(out_ch), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd0);

        // Fixed select: ch2 sends three beats while ch0 stays valid and is never granted.
        mode = 1'b0; sel = 2'd2;
        setch(0, 1'b1, 1'b0, dv(0, 0));
        setch(2, 1'b1, 1'b0, dv(2, 0));
        #1 chk("fix_idle_rdy", 64'(in_ready), 64'd0);
        tick();
        chk("fix_lock_rdy", 64'(in_ready), 64'b0100);
        chk("fix_lock_ov", 64'(out_valid), 64'd0);
        tick();
        chk("fix_a0_ov", 64'(out_valid), 64'd1);
        chk("fix_a0_data", out_data, dv(2, 0));
        chk("fix_a0_ch", 64'(out_ch), 64'd2);
        chk("fix_a0_last", 64'(out_last), 64'd0);
        setch(2, 1'b1, 1'b0, dv(2, 1));
        #1 chk("fix_a1_rdy", 64'(in_ready), 64'b0100);
        tick();
        chk("fix_a1_data", out_data, dv(2, 1));
        chk("fix_a1_last", 64'(out_last), 64'd0);
        setch(2, 1'b1, 1'b1, dv(2, 2));
        tick();
        chk("fix_a2_data", out_data, dv(2, 2));
        chk("fix_a2_last", 64'(out_last), 64'd1);
        chk("fix_a2_ch", 64'(out_ch), 64'd2);
        chk("fix_post_rdy", 64'(in_ready), 64'd0);
        setch(2, 1'b0, 1'b0, 64'd0);
        tick();
        chk("fix_drain_ov", 64'(out_valid), 64'd0);
        chk("fix_ch0_rdy", 64'(in_ready), 64'd0);
        tick();
        chk("fix_ch0_rdy2", 64'(in_ready), 64'd0);

        // Round-robin: ch0/1/3 each offer back-to-back 2-beat packets.
        do_reset();
        mode = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            for (int i = 0; i < 3; i++)
                setch(order[i], 1'b1, bc[order[i]][0], dv(order[i], bc[order[i]]));
            #1 rdy = in_ready;
            tick();
            for (int c = 0; c < 4; c++) if (rdy[c] && in_valid[c]) bc[c]++;
            if (k >= 2) begin
                int p, ph, ch, b;
                p  = (k - 2) / 3;
                ph = (k - 2) % 3;
                ch = order[p % 3];
                b  = (p / 3) * 2 + ph;
                if (ph == 2) begin
                    chk("rr_gap_ov", 64'(out_valid), 64'd0);
                end else begin
                    chk("rr_ov", 64'(out_valid), 64'd1);
                    chk("rr_ch", 64'(out_ch), 64'(ch));
                    chk("rr_data", out_data, dv(ch, b));
                    chk("rr_last", 64'(out_last), 64'(ph));
                end
            end
        end

        // Backpressure: 16-beat packet on ch1, out_ready low for cycles 6..10.
        do_reset();
        mode = 1'b0; sel = 2'd1; rx = 0;
        for (int k = 1; k <= 26; k++) begin
            out_ready = !(k >= 6 && k <= 10);
            setch(1, bc[1] < 16, bc[1] == 15, dv(1, bc[1]));
            #1 rdy = in_ready;
            ovt = out_valid && out_ready;
            od  = out_data;
`ifndef STREAM_MUX_SKID_EN
            if (k >= 6 && k <= 10) begin
                chk("bp_hold_data", out_data, dv(1, 3));
                chk("bp_hold_ov", 64'(out_valid), 64'd1);
                chk("bp_hold_rdy", 64'(rdy), 64'd0);
            end
`endif
            tick();
            if (rdy[1] && in_valid[1]) bc[1]++;
            if (ovt) begin
                chk("bp_beat", od, dv(1, rx));
                rx++;
            end
        end
        chk("bp_count", 64'(rx), 64'd16);

        // Asynchronous reset in the middle of a packet clears outputs without an edge.
        do_reset();
        mode = 1'b0; sel = 2'd2;
        setch(2, 1'b1, 1'b0, dv(2, 9));
        tick();
        tick();
        chk("mr_pre_ov", 64'(out_valid), 64'd1);
        chk("mr_pre_rdy", 64'(in_ready), 64'b0100);
        rst = 1'b1;
        #1;
        chk("mr_ov", 64'(out_valid), 64'd0);
        chk("mr_rdy", 64'(in_ready), 64'd0);
        chk("mr_ch", 64'(out_ch), 64'd0);
        chk("mr_last", 64'(out_last), 64'd0);
        chk("mr_data", out_data, 64'd0);
        do_reset();

        // Out-of-range select on a 3-channel instance never grants.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bad_sel_rdy", 64'(in_ready3), 64'd0);
            chk("bad_sel_ov", 64'(out_valid3), 64'd0);
        end
        sel3 = 2'd2;
        tick();
        chk("good_sel_rdy", 64'(in_ready3), 64'b100);
        in_valid3 = '0;

`ifdef STREAM_MUX_SKID_EN
        // Skid: 32-beat packet on ch0 with out_ready toggling every cycle.
        do_reset();
        mode = 1'b0; sel = 2'd0; rx = 0;
        for (int k = 1; k <= 90; k++) begin
            out_ready = k[0];
            setch(0, bc[0] < 32, bc[0] == 31, dv(0, bc[0]));
            #1 rdy = in_ready;
            out_ready = !out_ready;
            #1 chk("skid_rdy_reg", 64'(in_ready), 64'(rdy));
            out_ready = !out_ready;
            #1;
            ovt = out_valid && out_ready;
            od  = out_data;
            tick();
            if (rdy[0] && in_valid[0]) bc[0]++;
            if (ovt) begin
                chk("skid_beat", od, dv(0, rx));
                rx++;
            end
        end
        chk("skid_count", 64'(rx), 64'd32);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
